imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
- Instruction fetch sequencer in front of the combinational instruction memory (word-indexed, 32-bit, zero beyond MemoryBytesSize).
- Owns the PC and drives the memory read address every cycle.
- Buffers fetched {pc, instruction} pairs in a small prefetch FIFO toward decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap) and address faults.

Parameters:
- ResetPc, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- MemoryBytesSize, 256, byte size of instruction memory; fetches at pc >= this value fault.
- FifoDepth, 2, prefetch FIFO entries; power of two, >= 2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  start/continue fetching; level-sensitive.
- o_mem_addr  out  32  byte address to instruction memory (always the current PC).
- i_mem_data  in  32  instruction returned combinationally for o_mem_addr.
- o_valid  out  1  FIFO head valid toward decode.
- i_ready  in  1  decode accepts head this cycle.
- o_pc  out  32  PC of FIFO head.
- o_instruction  out  32  instruction of FIFO head.
- i_redirect_valid  in  1  redirect request.
- i_redirect_pc  in  32  redirect target.
- o_fault  out  1  sticky fetch fault (misaligned redirect or out-of-range PC).
- o_fault_addr  out  32  offending address, captured on fault entry.

Behaviour:
- Reset (async assert, sync-deassert assumed upstream):
  - state = IDLE, PC = ResetPc, FIFO empty.
  - o_valid = 0, o_pc = 0, o_instruction = 0, o_fault = 0, o_fault_addr = 0.
  - o_mem_addr = ResetPc.
- States: IDLE, RUN, FAULT.
  - IDLE -> RUN when i_enable = 1. No fetch is performed in IDLE.
  - RUN -> IDLE when i_enable = 0. FIFO contents are retained and still drain.
  - RUN -> FAULT when the current PC >= MemoryBytesSize at the moment a fetch would occur. Set o_fault_addr = PC, no push.
  - Any state -> FAULT on a redirect with i_redirect_pc[1:0] != 0. Set o_fault_addr = i_redirect_pc and flush the FIFO.
  - FAULT is exited only by reset.
- Fetch (RUN only):
  - A fetch occurs in a cycle when the FIFO is not full, or is full and pops this cycle.
  - On a fetch: push {PC, i_mem_data}, then PC <= PC + 4. 32-bit wrap is allowed arithmetically but is caught by the range fault first.
  - Throughput: 1 instruction per cycle while i_ready = 1. The first o_valid occurs 1 cycle after entering RUN, because the push is registered.
- Handshake:
  - Pop when o_valid & i_ready.
  - o_pc and o_instruction hold stable while o_valid = 1 and i_ready = 0.
- Redirect:
  - Highest priority, evaluated in any state except FAULT (where it is ignored).
  - Same cycle: FIFO flushed, meaning no push occurs and any pop that cycle is discarded. PC <= i_redirect_pc.
  - Next cycle: o_valid = 0; a fetch from the new PC occurs if in RUN.
  - A redirect in IDLE updates PC without leaving IDLE.
- Simultaneous events:
  - Redirect + pop: the pop still counts as consumed by decode; the flush applies.
  - Redirect + range fault on the old PC: the redirect wins and no fault is raised.
- Full FIFO with i_ready = 0: no fetch; PC and o_mem_addr hold.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e (IDLE, RUN, FAULT).
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr}.
  - localparam InstrBytes = 4.
- Sub-module fetch_fifo:
  - Parameterized synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Uses the same clock and reset ports.

Test Plan:
- Reset then i_enable = 1, i_ready = 1, memory words 0..3 = 0x13,0x93,0x113,0x193 -> o_valid rises 1 cycle after RUN. Heads are (0x0,0x13), (0x4,0x93), (0x8,0x113), (0xC,0x193) on consecutive cycles.
- i_ready = 0 for 5 cycles after the first fetch -> FIFO fills to 2 and o_mem_addr holds at 0x8. Head stays (0x0,0x13). On i_ready = 1, the stream resumes with no gap or duplicate.
- Redirect to 0x40 while the FIFO holds 2 entries -> next cycle o_valid = 0. The following heads are (0x40, mem[16]), (0x44, mem[17]).
- Redirect to 0x42 -> o_fault = 1, o_fault_addr = 0x42, FIFO empty, o_valid stays 0. A later redirect to 0x0 is ignored until reset.
- Run sequentially to PC 0xFC with MemoryBytesSize = 256 -> 0xFC is delivered. Then o_fault = 1, o_fault_addr = 0x100, and no entry with pc 0x100 is emitted.
- Assert i_rst_n low mid-stream (FIFO full, PC 0x20) -> all outputs return to their reset values immediately (async). After release with i_enable = 1, fetch restarts at ResetPc.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer and its prefetch FIFO.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] InstrBytes = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it in one cycle and
// overrides any push or pop in that cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push,
  input  fetch_entry_t wr_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  fetch_entry_t       mem_q [Depth];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        count_q;
  logic               wr_en;
  logic               rd_en;

  assign full  = (count_q == (AW+1)'(Depth));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign wr_en = push && !flush && (!full || pop);
  assign rd_en = pop && !flush && !empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads the combinational
// instruction memory and feeds decode through a small prefetch FIFO.
//
// state | meaning
// IDLE  | not fetching; FIFO still drains, redirects update PC only
// RUN   | one fetch per cycle whenever the FIFO has (or is making) room
// FAULT | sticky; misaligned redirect or out-of-range PC, left only by reset
module imem_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] ResetPc         = 32'h0000_0000,
  parameter int unsigned MemoryBytesSize = 256,
  parameter int unsigned FifoDepth       = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fault,
  output logic [31:0] o_fault_addr
);

  localparam logic [31:0] MemLimit = 32'(MemoryBytesSize);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fault_addr_q, fault_addr_d;

  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t fifo_head;
  fetch_entry_t fifo_wr;
  logic         push;
  logic         pop;
  logic         flush;
  logic         redirect_take;
  logic         redirect_bad;
  logic         fetch_slot;

  assign pop     = !fifo_empty && i_ready;
  assign fifo_wr = '{pc: pc_q, instr: i_mem_data};

  fetch_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .push     (push),
    .wr_entry (fifo_wr),
    .pop      (pop),
    .flush    (flush),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      pc_q         <= ResetPc;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fault_addr_d  = fault_addr_q;
    push          = 1'b0;
    flush         = 1'b0;
    redirect_take = i_redirect_valid && (state_q != FAULT);
    redirect_bad  = redirect_take && (i_redirect_pc[1:0] != 2'b00);
    fetch_slot    = (state_q == RUN) && i_enable && (!fifo_full || pop);

    // Redirect beats everything, including a range fault on the old PC.
    if (redirect_take) begin
      flush = 1'b1;
      if (redirect_bad) begin
        state_d      = FAULT;
        fault_addr_d = i_redirect_pc;
      end else begin
        pc_d = i_redirect_pc;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (i_enable) state_d = RUN;
        end
        RUN: begin
          if (!i_enable) begin
            state_d = IDLE;
          end else if (fetch_slot) begin
            if (pc_q >= MemLimit) begin
              state_d      = FAULT;
              fault_addr_d = pc_q;
            end else begin
              push = 1'b1;
              pc_d = pc_q + InstrBytes;
            end
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign o_mem_addr    = pc_q;
  assign o_valid       = !fifo_empty;
  assign o_pc          = fifo_empty ? '0 : fifo_head.pc;
  assign o_instruction = fifo_empty ? '0 : fifo_head.instr;
  assign o_fault       = (state_q == FAULT);
  assign o_fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit with a word-indexed instruction memory.
module tb_imem_fetch_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_enable;
  logic [31:0] o_mem_addr;
  logic [31:0] i_mem_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_fault;
  logic [31:0] o_fault_addr;

  logic [31:0] mem [64];
  int          n_tests = 0;
  int          n_fail  = 0;

  imem_fetch_unit #(
    .ResetPc         (32'h0000_0000),
    .MemoryBytesSize (256),
    .FifoDepth       (2)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_enable         (i_enable),
    .o_mem_addr       (o_mem_addr),
    .i_mem_data       (i_mem_data),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_pc             (o_pc),
    .o_instruction    (o_instruction),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_fault          (o_fault),
    .o_fault_addr     (o_fault_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  assign i_mem_data = (o_mem_addr < 32'd256) ? mem[o_mem_addr[7:2]] : 32'h0;

  // Word i holds 0x13 + i*0x80: 0x13, 0x93, 0x113, 0x193, ...
  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'h13 + (pc >> 2) * 32'h80;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n          = 1'b0;
    i_enable         = 1'b0;
    i_ready          = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 32'h0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
    chk({tag, "_pc"}, o_pc, pc);
    chk({tag, "_instr"}, o_instruction, instr);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          guard;

    for (int i = 0; i < 64; i++) mem[i] = 32'h13 + i * 32'h80;
    i_rst_n          = 1'b0;
    i_enable         = 1'b0;
    i_ready          = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 32'h0;
    #2;
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_instr", o_instruction, 32'h0);
    chk("rst_fault", {31'b0, o_fault}, 32'd0);
    chk("rst_fault_addr", o_fault_addr, 32'h0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    #1;
    i_rst_n  = 1'b1;

    // Streaming at one per cycle
    i_enable = 1'b1;
    i_ready  = 1'b1;
    tick();
    chk("run_first_cycle_valid", {31'b0, o_valid}, 32'd0);
    tick();
    chk_head("s0", 32'h0, 32'h13);
    tick();
    chk_head("s1", 32'h4, 32'h93);
    tick();
    chk_head("s2", 32'h8, 32'h113);
    tick();
    chk_head("s3", 32'hC, 32'h193);

    // Backpressure fills the FIFO and holds the PC
    do_reset();
    i_enable = 1'b1;
    i_ready  = 1'b0;
    tick();
    tick();
    chk_head("bp_first", 32'h0, 32'h13);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_head("bp_hold", 32'h0, 32'h13);
    end
    chk("bp_mem_addr", o_mem_addr, 32'h8);
    i_ready = 1'b1;
    tick();
    chk_head("bp_r1", 32'h4, 32'h93);
    tick();
    chk_head("bp_r2", 32'h8, 32'h113);
    tick();
    chk_head("bp_r3", 32'hC, 32'h193);

    // Redirect with a full FIFO (and a pop in the same cycle)
    do_reset();
    i_enable = 1'b1;
    i_ready  = 1'b0;
    tick();
    tick();
    tick();
    chk("rd_full_addr", o_mem_addr, 32'h8);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h40;
    i_ready          = 1'b1;
    tick();
    i_redirect_valid = 1'b0;
    chk("rd_valid_low", {31'b0, o_valid}, 32'd0);
    chk("rd_mem_addr", o_mem_addr, 32'h40);
    tick();
    chk_head("rd_h0", 32'h40, 32'h813);
    tick();
    chk_head("rd_h1", 32'h44, 32'h893);

    // Misaligned redirect faults and sticks
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h42;
    tick();
    i_redirect_valid = 1'b0;
    chk("mis_fault", {31'b0, o_fault}, 32'd1);
    chk("mis_fault_addr", o_fault_addr, 32'h42);
    chk("mis_valid", {31'b0, o_valid}, 32'd0);
    tick();
    chk("mis_valid2", {31'b0, o_valid}, 32'd0);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h0;
    tick();
    i_redirect_valid = 1'b0;
    tick();
    chk("mis_sticky_fault", {31'b0, o_fault}, 32'd1);
    chk("mis_sticky_addr", o_fault_addr, 32'h42);
    chk("mis_sticky_valid", {31'b0, o_valid}, 32'd0);

    // Sequential run to the end of memory, then range fault at 0x100
    do_reset();
    i_enable = 1'b1;
    i_ready  = 1'b1;
    exp_pc   = 32'h0;
    guard    = 0;
    while (exp_pc != 32'h100 && guard < 200) begin
      tick();
      guard++;
      if (o_valid) begin
        chk("seq_pc", o_pc, exp_pc);
        chk("seq_instr", o_instruction, exp_instr(exp_pc));
        exp_pc = exp_pc + 32'h4;
      end
    end
    chk("seq_reached_fc", exp_pc, 32'h100);
    tick();
    chk("rng_fault", {31'b0, o_fault}, 32'd1);
    chk("rng_fault_addr", o_fault_addr, 32'h100);
    chk("rng_valid", {31'b0, o_valid}, 32'd0);
    tick();
    tick();
    chk("rng_valid_later", {31'b0, o_valid}, 32'd0);

    // Async reset mid-stream with a full FIFO at PC 0x20
    do_reset();
    i_enable = 1'b1;
    i_ready  = 1'b1;
    guard    = 0;
    while (o_mem_addr != 32'h1C && guard < 40) begin
      tick();
      guard++;
    end
    chk("ar_reach_1c", o_mem_addr, 32'h1C);
    i_ready = 1'b0;
    tick();
    chk("ar_mem_addr", o_mem_addr, 32'h20);
    chk_head("ar_head", 32'h18, exp_instr(32'h18));
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, o_valid}, 32'd0);
    chk("ar_pc", o_pc, 32'h0);
    chk("ar_instr", o_instruction, 32'h0);
    chk("ar_addr", o_mem_addr, 32'h0);
    chk("ar_fault", {31'b0, o_fault}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    tick();
    chk("ar_restart_valid", {31'b0, o_valid}, 32'd0);
    tick();
    chk_head("ar_restart", 32'h0, 32'h13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
